// File: rtl/spi_dac_rx.sv
// spi_dac_rx: SPI responder mirroring the DAC input stage; LD-gated sample load.
// Define SPI_DAC_RX_AUTOLOAD_EN to load directly on a valid CS rise and ignore LD.
module spi_dac_rx #(
    parameter int FRAME_BITS  = 16,
    parameter int DATA_W      = 10,
    parameter int DATA_LSB    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              spi_sdi,
    input  logic              spi_sck,
    input  logic              spi_cs,
    input  logic              spi_ld,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        cfg_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              busy
);
    localparam int CW = $clog2(FRAME_BITS + 2);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    // Synchronisers are left unreset so a reset with CS held low cannot fake a CS edge afterwards.
    logic [SYNC_STAGES-1:0] sdi_q, sck_q, cs_q, ld_q;
    logic sck_d, cs_d, ld_d;
    logic sdi_s, sck_s, cs_s, ld_s;
    assign sdi_s = sdi_q[SYNC_STAGES-1];
    assign sck_s = sck_q[SYNC_STAGES-1];
    assign cs_s  = cs_q[SYNC_STAGES-1];
    assign ld_s  = ld_q[SYNC_STAGES-1];
    always_ff @(posedge sysclk) begin
        sdi_q <= {sdi_q[SYNC_STAGES-2:0], spi_sdi};
        sck_q <= {sck_q[SYNC_STAGES-2:0], spi_sck};
        cs_q  <= {cs_q[SYNC_STAGES-2:0], spi_cs};
        ld_q  <= {ld_q[SYNC_STAGES-2:0], spi_ld};
        sck_d <= sck_s;
        cs_d  <= cs_s;
        ld_d  <= ld_s;
    end
    logic sck_rise, cs_fall, cs_rise, ld_fall, sdi_bit;
    always_ff @(posedge sysclk) begin
        sdi_bit <= sdi_s;
        if (reset) begin
            sck_rise <= 1'b0;
            cs_fall  <= 1'b0;
            cs_rise  <= 1'b0;
            ld_fall  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            sck_rise <= sck_s & ~sck_d;
            cs_fall  <= ~cs_s & cs_d;
            cs_rise  <= cs_s & ~cs_d;
            ld_fall  <= ~ld_s & ld_d;
            busy     <= ~cs_s;
        end
    end
    state_t                state;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [FRAME_BITS-1:0] shreg, sh_nxt;
    logic                  frame_ok;
    always_comb begin
        sh_nxt   = sck_rise ? {shreg[FRAME_BITS-2:0], sdi_bit} : shreg;
        cnt_nxt  = (sck_rise && cnt != CW'(FRAME_BITS + 1)) ? cnt + CW'(1) : cnt;
        frame_ok = cnt_nxt == CW'(FRAME_BITS);
    end
`ifdef SPI_DAC_RX_AUTOLOAD_EN
    logic unused_ld;
    assign unused_ld = ld_fall;
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            data_out   <= '0;
            cfg_out    <= 4'b0011;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: if (cs_fall) begin
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    shreg <= sh_nxt;
                    cnt   <= cnt_nxt;
                    if (cs_rise) begin
                        state      <= IDLE;
                        frame_err  <= ~frame_ok;
                        data_valid <= frame_ok;
                        if (frame_ok) begin
                            data_out <= sh_nxt[DATA_LSB +: DATA_W];
                            cfg_out  <= sh_nxt[FRAME_BITS-1 -: 4];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic [FRAME_BITS-1:0] hold;
    logic                  pending, ld_late;
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            hold       <= '0;
            pending    <= 1'b0;
            ld_late    <= 1'b0;
            data_out   <= '0;
            cfg_out    <= 4'b0011;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: if (cs_fall) begin
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    shreg <= sh_nxt;
                    cnt   <= cnt_nxt;
                    if (cs_rise && !frame_ok) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (cs_rise) begin
                        hold    <= sh_nxt;
                        pending <= 1'b1;
                        ld_late <= ld_fall;
                        state   <= HOLD;
                    end
                end
                HOLD: if ((ld_fall || ld_late) && pending) begin
                    data_out   <= hold[DATA_LSB +: DATA_W];
                    cfg_out    <= hold[FRAME_BITS-1 -: 4];
                    data_valid <= 1'b1;
                    pending    <= 1'b0;
                    ld_late    <= 1'b0;
                    cnt        <= '0;
                    state      <= cs_fall ? SHIFT : IDLE;
                end else if (cs_fall) begin
                    frame_err <= 1'b1;
                    cnt       <= '0;
                    state     <= SHIFT;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_spi_dac_rx.sv
// tb_spi_dac_rx: randomized frames checked against a frame-level model of the DAC receive stage.
module tb_spi_dac_rx;
    logic       sysclk = 0, reset = 1, sdi = 0, sck = 0, cs = 1, ld = 1;
    logic [9:0] data_out;
    logic [3:0] cfg_out;
    logic       data_valid, frame_err, busy;
    int         total = 0, bad = 0;
    int         err_seen = 0, err_exp = 0;
    logic [15:0] exp_q[$];
    logic [13:0] cur = {4'b0011, 10'h000};
    bit         in_hold = 0;
    logic [15:0] held;
`ifdef SPI_DAC_RX_AUTOLOAD_EN
    localparam bit AUTO = 1;
`else
    localparam bit AUTO = 0;
`endif

    spi_dac_rx dut (
        .sysclk(sysclk), .reset(reset), .spi_sdi(sdi), .spi_sck(sck), .spi_cs(cs), .spi_ld(ld),
        .data_out(data_out), .cfg_out(cfg_out), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
    );

    always #10 sysclk = ~sysclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Per-cycle compare: outputs hold still except on a data_valid pulse, which must match the next expected load.
    always @(posedge sysclk) begin
        #1;
        if (reset) begin
            cur = {4'b0011, 10'h000};
            chk("rst_out", {cfg_out, data_out}, cur);
            chk("rst_flags", {data_valid, frame_err, busy}, 3'b000);
        end else if (data_valid) begin
            if (exp_q.size() == 0) chk("unexpected_dv", 1, 0);
            else begin
                logic [15:0] w;
                w = exp_q.pop_front();
                cur = {w[15:12], w[11:2]};
                chk("load", {cfg_out, data_out}, cur);
            end
            chk("dv_fe_overlap", frame_err, 0);
        end else begin
            chk("stable", {cfg_out, data_out}, cur);
        end
        if (!reset && frame_err) err_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic sck_bit(input bit b);
        sdi = b;
        tick($urandom_range(3, 5));
        sck = 1;
        tick($urandom_range(3, 5));
        sck = 0;
    endtask

    task automatic model_ld();
`ifndef SPI_DAC_RX_AUTOLOAD_EN
        if (in_hold) exp_q.push_back(held);
        in_hold = 0;
`endif
    endtask

    task automatic frame(input logic [15:0] w, input int n, input bit ld_at_rise);
        cs = 0;
`ifndef SPI_DAC_RX_AUTOLOAD_EN
        if (in_hold) err_exp++;
        in_hold = 0;
`endif
        tick(4);
        chk("busy_hi", busy, 1);
        for (int i = 0; i < n; i++) sck_bit(i < 16 ? w[15-i] : 1'($urandom));
        tick(3);
        cs = 1;
        if (ld_at_rise) ld = 0;
        if (n != 16) err_exp++;
        else begin
`ifdef SPI_DAC_RX_AUTOLOAD_EN
            exp_q.push_back(w);
`else
            in_hold = 1;
            held = w;
`endif
        end
        if (ld_at_rise) model_ld();
        tick(4);
        ld = 1;
        chk("busy_lo", busy, 0);
        tick($urandom_range(2, 6));
    endtask

    task automatic pulse_ld();
        ld = 0;
        model_ld();
        tick(4);
        ld = 1;
        tick(3);
    endtask

    task automatic settle(input string nm);
        tick(12);
        chk({nm, "_err"}, err_seen, err_exp);
        chk({nm, "_pend"}, exp_q.size(), 0);
    endtask

    initial begin
        int e0;
        tick(6);
        reset = 0;
        tick(2);
        chk("init_data", data_out, 10'h000);
        chk("init_cfg", cfg_out, 4'b0011);
        chk("init_busy", busy, 0);
        frame(16'h3554, 16, 0);
`ifdef SPI_DAC_RX_AUTOLOAD_EN
        settle("auto1");
        chk("auto1_data", data_out, 10'h155);
        pulse_ld();
`else
        // First edge sampling LD low is the next posedge; data_valid must rise on the 4th.
        ld = 0;
        model_ld();
        for (int k = 1; k <= 4; k++) begin
            @(posedge sysclk);
            #1;
            chk("lat_dv", data_valid, k == 4);
        end
        chk("lat_data", data_out, 10'h155);
        chk("lat_cfg", cfg_out, 4'b0011);
        @(negedge sysclk);
        ld = 1;
        tick(3);
`endif
        settle("f3554");
        frame(16'h3FFC, 16, 0);
        pulse_ld();
        settle("f3ffc");
        chk("d3ff", data_out, 10'h3FF);
        frame(16'h3000, 16, 0);
        settle("f3000");
        chk("noload", data_out, AUTO ? 10'h000 : 10'h3FF);
        pulse_ld();
        settle("ld3000");
        chk("d000", data_out, 10'h000);
        e0 = err_seen;
        frame(16'h3FFC, 15, 0);
        pulse_ld();
        settle("short");
        chk("short_err1", err_seen - e0, 1);
        chk("short_keep", data_out, 10'h000);
        e0 = err_seen;
        frame(16'h3FFC, 17, 0);
        pulse_ld();
        settle("long");
        chk("long_err1", err_seen - e0, 1);
        chk("long_keep", data_out, 10'h000);
        e0 = err_seen;
        frame(16'h3554, 16, 0);
        frame(16'h3AA8, 16, 0);
        pulse_ld();
        settle("overrun");
        chk("overrun_err", err_seen - e0, AUTO ? 0 : 1);
        chk("d2aa", data_out, 10'h2AA);
        cs = 0;
        tick(4);
        for (int i = 0; i < 8; i++) sck_bit(1'($urandom));
        reset = 1;
        exp_q.delete();
        in_hold = 0;
        tick(5);
        reset = 0;
        tick(3);
        cs = 1;
        tick(8);
        chk("rst_mid_data", data_out, 10'h000);
        chk("rst_mid_cfg", cfg_out, 4'b0011);
        settle("midrst");
        frame(16'h3554, 16, 0);
        pulse_ld();
        settle("after_rst");
        chk("after_rst_d", data_out, 10'h155);
        frame(16'h1234, 16, 1);
        settle("ld_at_rise");
        chk("ld_at_rise_d", data_out, 10'h08D);
        for (int r = 0; r < 40; r++) begin
            int nsel;
            nsel = $urandom_range(0, 5);
            frame(16'($urandom), nsel == 0 ? 15 : nsel == 1 ? 17 : 16, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) < 7) pulse_ld();
            tick($urandom_range(0, 5));
        end
        settle("random");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
